// File: rtl/radio_rssi_averager.sv
// RSSI averager: drives the divided RSSI ADC clock into the radio bridge and
// captures the returned samples. It publishes window sum/average and an energy-detect flag with hold-off.
module radio_rssi_averager #(
  parameter int CLK_DIV  = 4,
  parameter int LOG2_WIN = 4,
  parameter int HOLD_WIN = 2
) (
  input  logic                     converter_clock_in,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic [0:10+LOG2_WIN-1]   threshold,
  input  logic [0:9]               user_RSSI_ADC_D,
  output logic                     user_RSSI_ADC_clk,
  output logic [0:10+LOG2_WIN-1]   rssi_sum,
  output logic [0:9]               rssi_avg,
  output logic                     rssi_valid,
  output logic                     energy_det
);

  localparam int SW   = 10 + LOG2_WIN;
  localparam int DIVW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIVW-1:0] DIV_HALF  = DIVW'(CLK_DIV / 2);
  localparam logic [DIVW-1:0] DIV_LAST  = DIVW'(CLK_DIV - 1);
  localparam logic [3:0]      HOLD_INIT = 4'(HOLD_WIN);

  logic [DIVW-1:0]     div_cnt_q, div_cnt_d;
  logic                adc_clk_q, adc_clk_d;
  logic [9:0]          sample_q,  sample_d;
  logic                cap_q,     cap_d;
  logic [LOG2_WIN-1:0] smp_cnt_q, smp_cnt_d;
  logic [SW-1:0]       acc_q,     acc_d;
  logic [SW-1:0]       sum_q,     sum_d;
  logic [9:0]          avg_q,     avg_d;
  logic                valid_q,   valid_d;
  logic [3:0]          hold_q,    hold_d;
  logic                det_q,     det_d;

  logic [SW-1:0]       win_sum;
  logic                win_last;
  logic                div_at_last;

  assign win_sum     = acc_q + SW'(sample_q);
  assign win_last    = &smp_cnt_q;
  assign div_at_last = (div_cnt_q == DIV_LAST);

  // rssi_valid is a one-cycle strobe with no back-pressure: the consumer must
  // take rssi_sum/rssi_avg on that cycle; both hold until the next strobe.
  always_comb begin
    div_cnt_d = div_cnt_q;
    adc_clk_d = adc_clk_q;
    sample_d  = sample_q;
    cap_d     = 1'b0;
    smp_cnt_d = smp_cnt_q;
    acc_d     = acc_q;
    sum_d     = sum_q;
    avg_d     = avg_q;
    valid_d   = 1'b0;
    hold_d    = hold_q;
    det_d     = det_q;

    if (!enable) begin
      // Disabling discards the partial window and any capture still pending.
      div_cnt_d = '0;
      adc_clk_d = 1'b0;
      smp_cnt_d = '0;
      acc_d     = '0;
      hold_d    = '0;
      det_d     = 1'b0;
    end else begin
      adc_clk_d = (div_cnt_q < DIV_HALF);
      div_cnt_d = div_at_last ? '0 : div_cnt_q + DIVW'(1);
      cap_d     = div_at_last;
      if (div_at_last) begin
        sample_d = user_RSSI_ADC_D;
      end

      if (cap_q) begin
        if (win_last) begin
          sum_d     = win_sum;
          avg_d     = 10'(win_sum >> LOG2_WIN);
          valid_d   = 1'b1;
          acc_d     = '0;
          smp_cnt_d = '0;
          // Threshold is only looked at here, against the freshly completed sum.
          if (win_sum >= threshold) begin
            det_d  = 1'b1;
            hold_d = HOLD_INIT;
          end else if (hold_q != 4'd0) begin
            hold_d = hold_q - 4'd1;
            if (hold_q == 4'd1) begin
              det_d = 1'b0;
            end
          end
        end else begin
          acc_d     = win_sum;
          smp_cnt_d = smp_cnt_q + LOG2_WIN'(1);
        end
      end
    end
  end

  always_ff @(posedge converter_clock_in or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_q <= '0;
      adc_clk_q <= 1'b0;
      sample_q  <= '0;
      cap_q     <= 1'b0;
      smp_cnt_q <= '0;
      acc_q     <= '0;
      sum_q     <= '0;
      avg_q     <= '0;
      valid_q   <= 1'b0;
      hold_q    <= '0;
      det_q     <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      adc_clk_q <= adc_clk_d;
      sample_q  <= sample_d;
      cap_q     <= cap_d;
      smp_cnt_q <= smp_cnt_d;
      acc_q     <= acc_d;
      sum_q     <= sum_d;
      avg_q     <= avg_d;
      valid_q   <= valid_d;
      hold_q    <= hold_d;
      det_q     <= det_d;
    end
  end

  assign user_RSSI_ADC_clk = adc_clk_q;
  assign rssi_sum          = sum_q;
  assign rssi_avg          = avg_q;
  assign rssi_valid        = valid_q;
  assign energy_det        = det_q;

endmodule

// File: tb/tb_radio_rssi_averager.sv
// Bench for radio_rssi_averager: directed phases with random samples/thresholds,
// every cycle checked against a window-level model built from captured sample lists.
module tb_radio_rssi_averager;

  localparam int CLK_DIV  = 4;
  localparam int LOG2_WIN = 4;
  localparam int HOLD_WIN = 2;
  localparam int SW       = 10 + LOG2_WIN;
  localparam int WIN      = 1 << LOG2_WIN;

  // clock/reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          en  = 1'b0;
  logic [0:SW-1] thr = '0;
  logic [0:9]    d   = '0;
  logic          adc_clk;
  logic [0:SW-1] sum;
  logic [0:9]    avg;
  logic          vld;
  logic          det;

  radio_rssi_averager #(
    .CLK_DIV (CLK_DIV),
    .LOG2_WIN(LOG2_WIN),
    .HOLD_WIN(HOLD_WIN)
  ) dut (
    .converter_clock_in(clk),
    .reset_n           (rst_n),
    .enable            (en),
    .threshold         (thr),
    .user_RSSI_ADC_D   (d),
    .user_RSSI_ADC_clk (adc_clk),
    .rssi_sum          (sum),
    .rssi_avg          (avg),
    .rssi_valid        (vld),
    .energy_det        (det)
  );

  // reference model state
  int m;             // enabled edges since enable rose or reset released
  int win_q[$];      // samples captured in the current window
  int hist_q[$];     // per completed window: 1 if it met the threshold
  bit pend;
  int pend_sum;
  int e_sum, e_avg, e_vld, e_det, e_clk;
  int n_vec, n_err;
  int keep_sum;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m = 0;
    win_q.delete();
    hist_q.delete();
    pend  = 1'b0;
    e_sum = 0; e_avg = 0; e_vld = 0; e_det = 0; e_clk = 0;
  endtask

  // One rising edge: advance the model with the inputs as sampled, then check.
  task automatic tick();
    @(posedge clk);
    if (!en) begin
      m = 0;
      win_q.delete();
      hist_q.delete();
      pend  = 1'b0;
      e_vld = 0; e_det = 0; e_clk = 0;
    end else begin
      m++;
      e_clk = int'(((m - 1) % CLK_DIV) < (CLK_DIV / 2));
      e_vld = int'(pend);
      if (pend) begin
        e_sum = pend_sum;
        e_avg = pend_sum / WIN;
        hist_q.push_back(int'(pend_sum >= int'(thr)));
        e_det = 0;
        for (int i = 0; i < HOLD_WIN; i++)
          if (i < hist_q.size() && hist_q[hist_q.size() - 1 - i] != 0) e_det = 1;
        pend = 1'b0;
      end
      if (m % CLK_DIV == 0) begin
        win_q.push_back(int'(d));
        if (win_q.size() == WIN) begin
          pend_sum = win_q.sum();
          pend     = 1'b1;
          win_q.delete();
        end
      end
    end
    #2;
    chk("adc_clk", 32'(adc_clk), 32'(e_clk));
    chk("valid",   32'(vld),     32'(e_vld));
    chk("sum",     32'(sum),     32'(e_sum));
    chk("avg",     32'(avg),     32'(e_avg));
    chk("det",     32'(det),     32'(e_det));
  endtask

  // driver: mode 0 constant lo, mode 1 random lo..hi, mode 2 ramp 1,2,3.. per window
  task automatic run(input int n, input int mode, input int lo, input int hi);
    for (int i = 0; i < n; i++) begin
      case (mode)
        0:       d = 10'(lo);
        1:       d = 10'($urandom_range(hi, lo));
        default: d = 10'(win_q.size() + 1);
      endcase
      tick();
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    model_reset();
    thr = SW'(2000);

    #1;
    chk("rst_clk", 32'(adc_clk), 0);
    chk("rst_vld", 32'(vld), 0);
    chk("rst_sum", 32'(sum), 0);
    chk("rst_avg", 32'(avg), 0);
    chk("rst_det", 32'(det), 0);
    #12 rst_n = 1'b1;
    run(2, 0, 0, 0);

    // constant 100, threshold 2000
    en = 1'b1;
    run(129, 0, 100, 100);
    chk("c100_vld", 32'(vld), 1);
    chk("c100_sum", 32'(sum), 1600);
    chk("c100_avg", 32'(avg), 100);
    chk("c100_det", 32'(det), 0);

    // full scale, equality detect
    thr = SW'(16368);
    run(64, 0, 1023, 1023);
    chk("fs_sum", 32'(sum), 16368);
    chk("fs_avg", 32'(avg), 1023);
    chk("fs_det", 32'(det), 1);

    // ramp 1..16 -> 136, avg truncates to 8; detect held one window
    run(64, 2, 0, 0);
    chk("ramp_sum", 32'(sum), 136);
    chk("ramp_avg", 32'(avg), 8);
    chk("ramp_det_hold", 32'(det), 1);
    run(64, 1, 0, 1000);
    chk("ramp_det_clr", 32'(det), 0);

    // hold-off: above / below / below / above
    thr = SW'(5000);
    run(64, 1, 700, 1023);
    chk("hold_a1", 32'(det), 1);
    run(64, 1, 0, 300);
    chk("hold_b1", 32'(det), 1);
    run(64, 1, 0, 300);
    chk("hold_b2", 32'(det), 0);
    run(64, 1, 700, 1023);
    chk("hold_a2", 32'(det), 1);

    // random windows, threshold changed mid-window
    for (int w = 0; w < 6; w++) begin
      thr = SW'($urandom_range(16368, 0));
      run(32, 1, 0, 1023);
      thr = (w == 5) ? '0 : SW'($urandom_range(16368, 0));
      run(32, 1, 0, 1023);
    end
    chk("rnd_det_thr0", 32'(det), 1);

    // drop enable after 7 captures of a window of 900s
    keep_sum = e_sum;
    run(29, 0, 900, 900);
    en = 1'b0;
    run(10, 1, 0, 1023);
    chk("dis_clk", 32'(adc_clk), 0);
    chk("dis_vld", 32'(vld), 0);
    chk("dis_det", 32'(det), 0);
    chk("dis_sum", 32'(sum), 32'(keep_sum));
    en = 1'b1;
    run(64, 0, 50, 50);
    chk("reen_novld", 32'(vld), 0);
    run(1, 0, 50, 50);
    chk("reen_vld", 32'(vld), 1);
    chk("reen_sum", 32'(sum), 800);
    chk("reen_avg", 32'(avg), 50);
    chk("reen_det", 32'(det), 1);

    // asynchronous reset between edges
    run(20, 1, 0, 1023);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_clk", 32'(adc_clk), 0);
    chk("arst_vld", 32'(vld), 0);
    chk("arst_sum", 32'(sum), 0);
    chk("arst_avg", 32'(avg), 0);
    chk("arst_det", 32'(det), 0);
    #2 rst_n = 1'b1;
    model_reset();
    thr = SW'($urandom_range(16368, 0));
    run(129, 1, 0, 1023);
    chk("post_rst_vld", 32'(vld), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
